// File: rtl/axi_sram_slave.sv
// Single-port AXI4 slave memory: single-beat reads and writes with a fixed
// response latency. Independent read and write FSMs share one word array.
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 16,
  parameter int          LATENCY    = 2,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        reset,
  // AW channel
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  // W channel
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  // B channel
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  // AR channel
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  // R channel
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int          AW       = DEPTH_LOG2;
  localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_SLV = 2'b10;
  localparam logic [1:0]  RESP_DEC = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  // Address decode: unsigned offset wraps for addresses below the base, so a
  // single shift test covers both ends of the window.
  function automatic logic [1:0] resp_of(input logic [31:0] addr, input logic [7:0] len);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    if ((off >> (DEPTH_LOG2 + 2)) != 32'd0) return RESP_DEC;
    if (len != 8'd0)                        return RESP_SLV;
    return RESP_OK;
  endfunction

  function automatic logic [AW-1:0] index_of(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    return AW'(off >> 2);
  endfunction

  logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

  w_state_e      w_state_q;
  logic [AW-1:0] w_idx_q;
  logic [3:0]    w_cnt_q;
  logic [3:0]    bid_q;
  logic [1:0]    bresp_q;

  r_state_e      r_state_q;
  logic [AW-1:0] r_idx_q;
  logic [3:0]    r_cnt_q;
  logic [3:0]    rid_q;
  logic [1:0]    rresp_q;
  logic [31:0]   rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic r_load;
  logic [AW-1:0] rd_idx;
  logic [1:0]    rd_resp;

  // Readies and valids are gated by reset so nothing handshakes while it is low.
  assign io_slave_awready = reset && (w_state_q == W_IDLE);
  assign io_slave_wready  = reset && (w_state_q == W_DATA);
  assign io_slave_bvalid  = reset && (w_state_q == W_RESP);
  assign io_slave_arready = reset && (r_state_q == R_IDLE);
  assign io_slave_rvalid  = reset && (r_state_q == R_DATA);
  assign io_slave_rlast   = io_slave_rvalid;

  assign io_slave_bresp = bresp_q;
  assign io_slave_bid   = bid_q;
  assign io_slave_rresp = rresp_q;
  assign io_slave_rid   = rid_q;
  assign io_slave_rdata = rdata_q;

  assign aw_hs = io_slave_awvalid && io_slave_awready;
  assign w_hs  = io_slave_wvalid  && io_slave_wready;
  assign b_hs  = io_slave_bvalid  && io_slave_bready;
  assign ar_hs = io_slave_arvalid && io_slave_arready;
  assign r_hs  = io_slave_rvalid  && io_slave_rready;

  logic unused_ok;
  assign unused_ok = ^{io_slave_awsize, io_slave_awburst, io_slave_arsize,
                       io_slave_arburst, io_slave_wlast};

  // Write channel FSM.
  // NOTE: reset is synchronous and active-low, so it lives inside the clocked
  // branch; every state register uses non-blocking assignment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      bid_q     <= '0;
      bresp_q   <= RESP_OK;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          w_idx_q   <= index_of(io_slave_awaddr);
          bid_q     <= io_slave_awid;
          bresp_q   <= resp_of(io_slave_awaddr, io_slave_awlen);
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_cnt_q   <= '0;
          w_state_q <= (LATENCY == 0) ? W_RESP : W_WAIT;
        end
        W_WAIT: begin
          if (w_cnt_q == LAT_LAST) begin
            w_cnt_q   <= '0;
            w_state_q <= W_RESP;
          end else begin
            w_cnt_q <= w_cnt_q + 4'd1;
          end
        end
        W_RESP: if (b_hs) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents survive reset.
  always_ff @(posedge clock) begin
    if (w_hs && (bresp_q == RESP_OK)) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) mem[w_idx_q][8*b +: 8] <= io_slave_wdata[8*b +: 8];
      end
    end
  end

  // The array is sampled on the edge that enters R_DATA; with LATENCY=0 that
  // is the AR handshake edge itself, so the index comes straight from araddr.
  assign r_load  = ((r_state_q == R_IDLE) && ar_hs && (LATENCY == 0)) ||
                   ((r_state_q == R_WAIT) && (r_cnt_q == LAT_LAST));
  assign rd_idx  = (r_state_q == R_IDLE) ? index_of(io_slave_araddr) : r_idx_q;
  assign rd_resp = (r_state_q == R_IDLE) ? resp_of(io_slave_araddr, io_slave_arlen) : rresp_q;

  // Read channel FSM.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= RESP_OK;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          r_idx_q   <= index_of(io_slave_araddr);
          rid_q     <= io_slave_arid;
          rresp_q   <= resp_of(io_slave_araddr, io_slave_arlen);
          r_cnt_q   <= '0;
          r_state_q <= (LATENCY == 0) ? R_DATA : R_WAIT;
        end
        R_WAIT: begin
          if (r_cnt_q == LAT_LAST) begin
            r_cnt_q   <= '0;
            r_state_q <= R_DATA;
          end else begin
            r_cnt_q <= r_cnt_q + 4'd1;
          end
        end
        R_DATA: if (r_hs) r_state_q <= R_IDLE;
        default: r_state_q <= R_IDLE;
      endcase
      if (r_load) rdata_q <= (rd_resp == RESP_DEC) ? 32'd0 : mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (LATENCY=2): fetch, strobed stores, stall,
// error responses, read/write overlap and reset mid-transaction.
module tb_axi_sram_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_slave_awvalid = 1'b0, io_slave_awready;
  logic [31:0] io_slave_awaddr  = '0;
  logic [3:0]  io_slave_awid    = '0;
  logic [7:0]  io_slave_awlen   = '0;
  logic [2:0]  io_slave_awsize  = 3'd2;
  logic [1:0]  io_slave_awburst = 2'd1;
  logic        io_slave_wvalid  = 1'b0, io_slave_wready;
  logic [31:0] io_slave_wdata   = '0;
  logic [3:0]  io_slave_wstrb   = '0;
  logic        io_slave_wlast   = 1'b0;
  logic        io_slave_bvalid, io_slave_bready = 1'b0;
  logic [1:0]  io_slave_bresp;
  logic [3:0]  io_slave_bid;
  logic        io_slave_arvalid = 1'b0, io_slave_arready;
  logic [31:0] io_slave_araddr  = '0;
  logic [3:0]  io_slave_arid    = '0;
  logic [7:0]  io_slave_arlen   = '0;
  logic [2:0]  io_slave_arsize  = 3'd2;
  logic [1:0]  io_slave_arburst = 2'd1;
  logic        io_slave_rvalid, io_slave_rready = 1'b0;
  logic [1:0]  io_slave_rresp;
  logic [31:0] io_slave_rdata;
  logic        io_slave_rlast;
  logic [3:0]  io_slave_rid;

  int checks = 0;
  int failures = 0;

  axi_sram_slave #(.LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .io_slave_awvalid(io_slave_awvalid), .io_slave_awready(io_slave_awready),
    .io_slave_awaddr(io_slave_awaddr), .io_slave_awid(io_slave_awid),
    .io_slave_awlen(io_slave_awlen), .io_slave_awsize(io_slave_awsize),
    .io_slave_awburst(io_slave_awburst),
    .io_slave_wvalid(io_slave_wvalid), .io_slave_wready(io_slave_wready),
    .io_slave_wdata(io_slave_wdata), .io_slave_wstrb(io_slave_wstrb),
    .io_slave_wlast(io_slave_wlast),
    .io_slave_bvalid(io_slave_bvalid), .io_slave_bready(io_slave_bready),
    .io_slave_bresp(io_slave_bresp), .io_slave_bid(io_slave_bid),
    .io_slave_arvalid(io_slave_arvalid), .io_slave_arready(io_slave_arready),
    .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid),
    .io_slave_arlen(io_slave_arlen), .io_slave_arsize(io_slave_arsize),
    .io_slave_arburst(io_slave_arburst),
    .io_slave_rvalid(io_slave_rvalid), .io_slave_rready(io_slave_rready),
    .io_slave_rresp(io_slave_rresp), .io_slave_rdata(io_slave_rdata),
    .io_slave_rlast(io_slave_rlast), .io_slave_rid(io_slave_rid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a negedge; outputs are sampled there.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [7:0] len,
                          input logic [3:0] id, input bit bready_tied,
                          output logic [1:0] resp, output logic [3:0] bid,
                          output int lat, output bit after_ok);
    int n;
    bit overlap;
    overlap = 0;
    io_slave_awvalid = 1'b1; io_slave_awaddr = addr; io_slave_awlen = len; io_slave_awid = id;
    io_slave_bready  = bready_tied;
    n = 0;
    while (!io_slave_awready && n < 20) begin @(negedge clock); n++; end
    if (io_slave_wready) overlap = 1;
    @(negedge clock);
    io_slave_awvalid = 1'b0;
    io_slave_wvalid = 1'b1; io_slave_wdata = data; io_slave_wstrb = strb; io_slave_wlast = 1'b1;
    n = 0;
    while (!io_slave_wready && n < 20) begin
      if (io_slave_awready) overlap = 1;
      @(negedge clock); n++;
    end
    if (io_slave_awready) overlap = 1;
    @(negedge clock);
    io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
    lat = 1;
    while (!io_slave_bvalid && lat < 40) begin @(negedge clock); lat++; end
    resp = io_slave_bresp;
    bid  = io_slave_bid;
    io_slave_bready = 1'b1;
    @(negedge clock);
    io_slave_bready = 1'b0;
    after_ok = io_slave_awready && !io_slave_bvalid;
    check("wr_aw_w_exclusive", 32'(overlap), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input int stall,
                         output logic [31:0] data, output logic [1:0] resp,
                         output logic [3:0] rid, output int lat,
                         output bit stable, output bit ar_low, output bit after_ok);
    int n;
    io_slave_arvalid = 1'b1; io_slave_araddr = addr; io_slave_arid = id; io_slave_arlen = len;
    n = 0;
    while (!io_slave_arready && n < 20) begin @(negedge clock); n++; end
    @(negedge clock);
    io_slave_arvalid = 1'b0;
    ar_low = 1;
    lat = 1;
    while (!io_slave_rvalid && lat < 40) begin
      if (io_slave_arready) ar_low = 0;
      @(negedge clock); lat++;
    end
    if (io_slave_arready) ar_low = 0;
    data = io_slave_rdata; resp = io_slave_rresp; rid = io_slave_rid;
    stable = io_slave_rlast;
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      if (io_slave_rdata !== data || io_slave_rresp !== resp || io_slave_rid !== rid ||
          !io_slave_rvalid || !io_slave_rlast || io_slave_arready) stable = 0;
    end
    io_slave_rready = 1'b1;
    @(negedge clock);
    io_slave_rready = 1'b0;
    after_ok = io_slave_arready && !io_slave_rvalid;
  endtask

  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;
  int          wr_lat;
  bit          wr_after;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [3:0]  rd_id;
  int          rd_lat;
  bit          rd_stable, rd_arlow, rd_after;
  bit          seen;
  int          n;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_readies", 32'({io_slave_awready, io_slave_wready, io_slave_arready}), 32'd0);
    check("rst_valids", 32'({io_slave_rvalid, io_slave_bvalid}), 32'd0);
    check("rst_rdata", io_slave_rdata, 32'd0);
    check("rst_resp_id", 32'({io_slave_rresp, io_slave_bresp, io_slave_rid, io_slave_bid}), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_readies", 32'({io_slave_awready, io_slave_wready, io_slave_arready}), 32'b101);

    // Boot word, then reset: the array must survive it
    do_write(32'h8000_0000, 32'h0000_0413, 4'hF, 8'd0, 4'd3, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    check("w0_bresp", 32'(wr_resp), 32'd0);
    check("w0_bid", 32'(wr_bid), 32'd3);
    check("w0_lat", 32'(wr_lat), 32'd3);
    check("w0_b2b_awready", 32'(wr_after), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("rst2_awready", 32'(io_slave_awready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Fetch
    do_read(32'h8000_0000, 4'd5, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("fetch_rdata", rd_data, 32'h0000_0413);
    check("fetch_rresp", 32'(rd_resp), 32'd0);
    check("fetch_rid", 32'(rd_id), 32'd5);
    check("fetch_lat", 32'(rd_lat), 32'd3);
    check("fetch_arready_low", 32'(rd_arlow), 32'd1);
    check("fetch_rlast", 32'(rd_stable), 32'd1);

    // Byte-strobe store (second write with bready tied high)
    do_write(32'h8000_0010, 32'hAABB_CCDD, 4'hF, 8'd0, 4'd1, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    check("st1_lat", 32'(wr_lat), 32'd3);
    do_write(32'h8000_0010, 32'h0000_0011, 4'b0001, 8'd0, 4'd2, 1'b1, wr_resp, wr_bid, wr_lat, wr_after);
    check("st2_lat", 32'(wr_lat), 32'd3);
    check("st2_bid", 32'(wr_bid), 32'd2);
    check("st2_b_one_cycle", 32'(wr_after), 32'd1);

    // Readback with a 5-cycle stall
    do_read(32'h8000_0010, 4'd9, 8'd0, 5, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("st_rdata", rd_data, 32'hAABB_CC11);
    check("st_rid", 32'(rd_id), 32'd9);
    check("stall_stable", 32'(rd_stable), 32'd1);
    check("stall_b2b_arready", 32'(rd_after), 32'd1);

    // Address window edges and error responses
    do_read(32'h7FFF_FFFC, 4'd2, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("below_rresp", 32'(rd_resp), 32'd3);
    check("below_rdata", rd_data, 32'd0);
    do_read(32'h8004_0000, 4'd2, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("above_rresp", 32'(rd_resp), 32'd3);
    do_write(32'h8003_FFFC, 32'h5A5A_5A5A, 4'hF, 8'd0, 4'd4, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    check("last_bresp", 32'(wr_resp), 32'd0);
    do_read(32'h8003_FFFC, 4'd4, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("last_rdata", rd_data, 32'h5A5A_5A5A);
    check("last_rresp", 32'(rd_resp), 32'd0);
    do_write(32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 8'd0, 4'd6, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    check("below_bresp", 32'(wr_resp), 32'd3);
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 8'd1, 4'd7, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    check("len1_bresp", 32'(wr_resp), 32'd2);
    check("len1_bid", 32'(wr_bid), 32'd7);
    do_read(32'h8000_0010, 4'd1, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("len1_unchanged", rd_data, 32'hAABB_CC11);
    do_read(32'h8000_0010, 4'd1, 8'd1, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("len1_rresp", 32'(rd_resp), 32'd2);

    // Read issued while a write to the same word sits in W_WAIT
    do_write(32'h8000_0020, 32'h1111_1111, 4'hF, 8'd0, 4'd0, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    io_slave_awvalid = 1'b1; io_slave_awaddr = 32'h8000_0020; io_slave_awid = 4'd1; io_slave_awlen = 8'd0;
    @(negedge clock);
    io_slave_awvalid = 1'b0;
    io_slave_wvalid = 1'b1; io_slave_wdata = 32'h1234_5678; io_slave_wstrb = 4'hF; io_slave_wlast = 1'b1;
    check("conc_wready", 32'(io_slave_wready), 32'd1);
    @(negedge clock);
    io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
    io_slave_arvalid = 1'b1; io_slave_araddr = 32'h8000_0020; io_slave_arid = 4'd4; io_slave_arlen = 8'd0;
    check("conc_arready", 32'(io_slave_arready), 32'd1);
    @(negedge clock);
    io_slave_arvalid = 1'b0;
    io_slave_bready = 1'b1;
    n = 0;
    while (!io_slave_rvalid && n < 20) begin @(negedge clock); n++; end
    check("conc_rdata_new", io_slave_rdata, 32'h1234_5678);
    io_slave_rready = 1'b1;
    @(negedge clock);
    io_slave_rready = 1'b0; io_slave_bready = 1'b0;
    check("conc_both_idle", 32'({io_slave_awready, io_slave_arready, io_slave_bvalid, io_slave_rvalid}), 32'b1100);

    // Write commit on the same edge that enters R_DATA returns pre-write data
    do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 8'd0, 4'd0, 1'b0, wr_resp, wr_bid, wr_lat, wr_after);
    io_slave_awvalid = 1'b1; io_slave_awaddr = 32'h8000_0030; io_slave_awid = 4'd2;
    io_slave_arvalid = 1'b1; io_slave_araddr = 32'h8000_0030; io_slave_arid = 4'd6;
    @(negedge clock);
    io_slave_awvalid = 1'b0; io_slave_arvalid = 1'b0;
    check("same_wready", 32'(io_slave_wready), 32'd1);
    @(negedge clock);
    io_slave_wvalid = 1'b1; io_slave_wdata = 32'h0BAD_BEEF; io_slave_wstrb = 4'hF; io_slave_wlast = 1'b1;
    @(negedge clock);
    io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
    check("same_rvalid", 32'(io_slave_rvalid), 32'd1);
    check("same_rdata_old", io_slave_rdata, 32'hCAFE_F00D);
    io_slave_rready = 1'b1; io_slave_bready = 1'b1;
    @(negedge clock);
    io_slave_rready = 1'b0;
    repeat (4) @(negedge clock);
    io_slave_bready = 1'b0;
    check("same_w_done", 32'(io_slave_awready), 32'd1);
    do_read(32'h8000_0030, 4'd6, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("same_rdata_new", rd_data, 32'h0BAD_BEEF);

    // Reset during R_WAIT abandons the read
    io_slave_arvalid = 1'b1; io_slave_araddr = 32'h8000_0010; io_slave_arid = 4'd7;
    @(negedge clock);
    io_slave_arvalid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_arready", 32'(io_slave_arready), 32'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (io_slave_rvalid) seen = 1;
    end
    check("midrst_no_rvalid", 32'(seen), 32'd0);
    check("midrst_arready_after", 32'(io_slave_arready), 32'd1);
    do_read(32'h8000_0010, 4'd8, 8'd0, 0, rd_data, rd_resp, rd_id, rd_lat, rd_stable, rd_arlow, rd_after);
    check("midrst_fresh_rdata", rd_data, 32'hAABB_CC11);
    check("midrst_fresh_lat", 32'(rd_lat), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
